// File: rtl/udp_pkg.sv
// ---------------------------------------------------------------------------
// udp_pkg
// Shared types and helpers for the UDP AXI-Stream emitter.
//   state_t       : emitter FSM states (IDLE, HDR0, HDR1, PAY)
//   udp_head_t    : UDP header fields as carried by the parsed record
//   UDP_HDR_BYTES : size of the UDP header in bytes
//   keep_from_rem : tkeep pattern for the final payload beat, given len%4
// ---------------------------------------------------------------------------
package udp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR0 = 2'd1,
      HDR1 = 2'd2,
      PAY  = 2'd3
   } state_t;

   typedef struct packed {
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] length;
      logic [15:0] checksum;
   } udp_head_t;

   localparam int UDP_HDR_BYTES = 8;

   // A remainder of 0 means the last beat is full.
   function automatic logic [3:0] keep_from_rem(input logic [1:0] rem);
      logic [3:0] keep;
      case (rem)
         2'd1:    keep = 4'h1;
         2'd2:    keep = 4'h3;
         2'd3:    keep = 4'h7;
         default: keep = 4'hF;
      endcase
      return keep;
   endfunction

endpackage

// File: rtl/udp_beat_mux.sv
// ---------------------------------------------------------------------------
// udp_beat_mux
// Combinational payload beat selection. For a beat index and an effective
// payload length it returns the 32-bit lane (bytes 4k..4k+3, byte 4k in
// [7:0]), its tkeep, and whether this is the final payload beat. Lanes whose
// keep bit is 0 are forced to zero.
// Ports:
//   data     : registered payload, byte i = bits [8i+7:8i]
//   eff_len  : effective payload length in bytes (1..PAYLOAD_BYTES when used)
//   beat_idx : payload beat index
//   lane     : selected, masked 32-bit beat data
//   keep     : byte enables for the beat
//   last     : beat is the final payload beat
// ---------------------------------------------------------------------------
module udp_beat_mux
   import udp_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 64,
   parameter int BEAT_W        = 5,
   parameter int LEN_W         = 7
) (
   input  logic [PAYLOAD_BYTES*8-1:0] data,
   input  logic [LEN_W-1:0]           eff_len,
   input  logic [BEAT_W-1:0]          beat_idx,
   output logic [31:0]                lane,
   output logic [3:0]                 keep,
   output logic                       last
);

   localparam int BEATS = PAYLOAD_BYTES / 4;

   logic [31:0]      raw_lane;
   logic [LEN_W-1:0] last_idx;
   logic [LEN_W-1:0] idx_ext;

   // Index of the final beat is (eff_len-1)/4; eff_len==0 never reaches here.
   assign last_idx = (eff_len - LEN_W'(1)) >> 2;
   assign idx_ext  = LEN_W'(beat_idx);
   assign last     = (idx_ext == last_idx);
   assign keep     = last ? keep_from_rem(eff_len[1:0]) : 4'hF;

   always_comb begin
      raw_lane = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_idx == BEAT_W'(b)) begin
            raw_lane = data[b*32 +: 32];
         end
      end
   end

   always_comb begin
      lane = '0;
      for (int i = 0; i < 4; i++) begin
         lane[i*8 +: 8] = keep[i] ? raw_lane[i*8 +: 8] : 8'h00;
      end
   end

endmodule

// File: rtl/udp_axis_emitter.sv
// ---------------------------------------------------------------------------
// udp_axis_emitter
// Takes one parsed UDP record per handshake and re-serialises it onto a
// 32-bit AXI-Stream master: two header beats ({dst,src}, {checksum,length})
// followed by ceil(eff_len/4) payload beats. eff_len = min(len, PAYLOAD_BYTES);
// an oversize record is truncated and flagged with tuser on its tlast beat.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high. io_in_ready is high only in IDLE. io_axis_tvalid, once high,
// stays high and all beat fields stay stable until the sink accepts it; the
// sink's tready is ignored while tvalid is low.
//
// All AXIS outputs are registered; the next beat is computed from the next
// FSM state and loaded only on a handshake, so tready never reaches tdata
// combinationally.
//
// Optional build macro UDP_EMIT_LEN_CHECK_EN: when defined, the UDP length
// field is compared against len+8 (modulo 2^16) and a mismatch also raises
// tuser on the tlast beat; the frame itself is unchanged.
//
// Ports:
//   clock, reset (async, active-low)
//   io_in_*      : record input (valid/ready, payload, length, UDP header)
//   io_axis_*    : AXI-Stream master (tvalid/tready, tdata, tkeep, tlast,
//                  tuser = frame error on the tlast beat)
// ---------------------------------------------------------------------------
module udp_axis_emitter
   import udp_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 64,
   parameter int TDATA_W       = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       io_in_valid,
   output logic                       io_in_ready,
   input  logic [PAYLOAD_BYTES*8-1:0] io_in_bits_data,
   input  logic [15:0]                io_in_bits_len,
   input  logic [15:0]                io_in_bits_udp_head_src_port,
   input  logic [15:0]                io_in_bits_udp_head_dst_port,
   input  logic [15:0]                io_in_bits_udp_head_length,
   input  logic [15:0]                io_in_bits_udp_head_checksum,
   output logic                       io_axis_tvalid,
   input  logic                       io_axis_tready,
   output logic [TDATA_W-1:0]         io_axis_tdata,
   output logic [3:0]                 io_axis_tkeep,
   output logic                       io_axis_tlast,
   output logic                       io_axis_tuser
);

   localparam int BEATS  = PAYLOAD_BYTES / 4;
   localparam int BEAT_W = $clog2(BEATS) + 1;
   localparam int LEN_W  = $clog2(PAYLOAD_BYTES + 1);

   if (TDATA_W != 32) begin : g_bad_tdata_w
      $error("udp_axis_emitter: only TDATA_W=32 is supported");
   end
   if ((PAYLOAD_BYTES % 4) != 0) begin : g_bad_payload_bytes
      $error("udp_axis_emitter: PAYLOAD_BYTES must be a multiple of 4");
   end

   // ------------------------------------------------------------------
   // Record capture
   // ------------------------------------------------------------------
   udp_head_t                  in_head;
   logic                       hs_in;
   logic                       hs_out;
   logic [LEN_W-1:0]           eff_len_d;
   logic                       oversize_d;
   logic                       len_err_d;

   logic [PAYLOAD_BYTES*8-1:0] data_q;
   logic [LEN_W-1:0]           eff_len_q;
   logic [15:0]                length_q;
   logic [15:0]                csum_q;
   logic                       oversize_q;
   logic                       len_err_q;

   assign in_head.src_port = io_in_bits_udp_head_src_port;
   assign in_head.dst_port = io_in_bits_udp_head_dst_port;
   assign in_head.length   = io_in_bits_udp_head_length;
   assign in_head.checksum = io_in_bits_udp_head_checksum;

   logic in_ready_q;
   logic tvalid_q;

   assign hs_in  = io_in_valid && in_ready_q;
   assign hs_out = tvalid_q && io_axis_tready;

   assign oversize_d = (io_in_bits_len > 16'(PAYLOAD_BYTES));
   assign eff_len_d  = oversize_d ? LEN_W'(PAYLOAD_BYTES)
                                  : io_in_bits_len[LEN_W-1:0];

`ifdef UDP_EMIT_LEN_CHECK_EN
   assign len_err_d = (in_head.length != (io_in_bits_len + 16'(UDP_HDR_BYTES)));
`else
   assign len_err_d = 1'b0;
`endif

   // src/dst go straight into the HDR0 beat register; only the fields
   // needed later are kept here.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_q     <= '0;
         eff_len_q  <= '0;
         length_q   <= '0;
         csum_q     <= '0;
         oversize_q <= 1'b0;
         len_err_q  <= 1'b0;
      end else if (hs_in) begin
         data_q     <= io_in_bits_data;
         eff_len_q  <= eff_len_d;
         length_q   <= in_head.length;
         csum_q     <= in_head.checksum;
         oversize_q <= oversize_d;
         len_err_q  <= len_err_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register / next-state / registered-output next values
   // ------------------------------------------------------------------
   state_t            state_q;
   state_t            state_d;
   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;

   logic [31:0]       tdata_q;
   logic [31:0]       tdata_d;
   logic [3:0]        tkeep_q;
   logic [3:0]        tkeep_d;
   logic              tlast_q;
   logic              tlast_d;
   logic              tuser_q;
   logic              tuser_d;
   logic              tvalid_d;
   logic              in_ready_d;

   logic [31:0]       mux_lane;
   logic [3:0]        mux_keep;
   logic              mux_last;
   logic              frame_err;

   assign frame_err = oversize_q | len_err_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         in_ready_q <= 1'b0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tlast_q    <= 1'b0;
         tuser_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         in_ready_q <= in_ready_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         tkeep_q    <= tkeep_d;
         tlast_q    <= tlast_d;
         tuser_q    <= tuser_d;
      end
   end

   // tlast_q marks the final beat of the frame in both HDR1 and PAY.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (hs_in) state_d = HDR0;
         end
         HDR0: begin
            if (hs_out) state_d = HDR1;
         end
         HDR1: begin
            if (hs_out) begin
               state_d = tlast_q ? IDLE : PAY;
               beat_d  = '0;
            end
         end
         PAY: begin
            if (hs_out) begin
               if (tlast_q) begin
                  state_d = IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase
   end

   udp_beat_mux #(
      .PAYLOAD_BYTES (PAYLOAD_BYTES),
      .BEAT_W        (BEAT_W),
      .LEN_W         (LEN_W)
   ) u_beat_mux (
      .data     (data_q),
      .eff_len  (eff_len_q),
      .beat_idx (beat_d),
      .lane     (mux_lane),
      .keep     (mux_keep),
      .last     (mux_last)
   );

   // Beat registers change only on an accepted transfer, which keeps them
   // stable through sink stalls.
   always_comb begin
      tvalid_d   = tvalid_q;
      tdata_d    = tdata_q;
      tkeep_d    = tkeep_q;
      tlast_d    = tlast_q;
      tuser_d    = tuser_q;
      in_ready_d = (state_d == IDLE);
      if (hs_in || hs_out) begin
         case (state_d)
            HDR0: begin
               tvalid_d = 1'b1;
               tdata_d  = {in_head.dst_port, in_head.src_port};
               tkeep_d  = 4'hF;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
            end
            HDR1: begin
               tvalid_d = 1'b1;
               tdata_d  = {csum_q, length_q};
               tkeep_d  = 4'hF;
               tlast_d  = (eff_len_q == '0);
               tuser_d  = (eff_len_q == '0) && frame_err;
            end
            PAY: begin
               tvalid_d = 1'b1;
               tdata_d  = mux_lane;
               tkeep_d  = mux_keep;
               tlast_d  = mux_last;
               tuser_d  = mux_last && frame_err;
            end
            default: begin
               tvalid_d = 1'b0;
               tdata_d  = '0;
               tkeep_d  = '0;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
            end
         endcase
      end
   end

   assign io_in_ready    = in_ready_q;
   assign io_axis_tvalid = tvalid_q;
   assign io_axis_tdata  = tdata_q;
   assign io_axis_tkeep  = tkeep_q;
   assign io_axis_tlast  = tlast_q;
   assign io_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_udp_axis_emitter.sv
// ---------------------------------------------------------------------------
// tb_udp_axis_emitter
// Directed bench for udp_axis_emitter (PAYLOAD_BYTES=64). Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising
// edge. Each expected beat is packed as {tdata, tkeep, tlast, tuser}.
// ---------------------------------------------------------------------------
module tb_udp_axis_emitter;

   localparam int PB = 64;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            io_in_valid = 1'b0;
   logic            io_in_ready;
   logic [PB*8-1:0] io_in_bits_data = '0;
   logic [15:0]     io_in_bits_len = '0;
   logic [15:0]     io_in_bits_udp_head_src_port = '0;
   logic [15:0]     io_in_bits_udp_head_dst_port = '0;
   logic [15:0]     io_in_bits_udp_head_length = '0;
   logic [15:0]     io_in_bits_udp_head_checksum = '0;
   logic            io_axis_tvalid;
   logic            io_axis_tready = 1'b0;
   logic [31:0]     io_axis_tdata;
   logic [3:0]      io_axis_tkeep;
   logic            io_axis_tlast;
   logic            io_axis_tuser;

   udp_axis_emitter #(
      .PAYLOAD_BYTES (PB),
      .TDATA_W       (32)
   ) dut (
      .clock                        (clock),
      .reset                        (reset),
      .io_in_valid                  (io_in_valid),
      .io_in_ready                  (io_in_ready),
      .io_in_bits_data              (io_in_bits_data),
      .io_in_bits_len               (io_in_bits_len),
      .io_in_bits_udp_head_src_port (io_in_bits_udp_head_src_port),
      .io_in_bits_udp_head_dst_port (io_in_bits_udp_head_dst_port),
      .io_in_bits_udp_head_length   (io_in_bits_udp_head_length),
      .io_in_bits_udp_head_checksum (io_in_bits_udp_head_checksum),
      .io_axis_tvalid               (io_axis_tvalid),
      .io_axis_tready               (io_axis_tready),
      .io_axis_tdata                (io_axis_tdata),
      .io_axis_tkeep                (io_axis_tkeep),
      .io_axis_tlast                (io_axis_tlast),
      .io_axis_tuser                (io_axis_tuser)
   );

   // ------------------------------------------------------------------
   // Clock
   // ------------------------------------------------------------------
   always #5 clock = ~clock;

   // ------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [37:0] exp_q[$];
   logic [37:0] got_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [37:0] beat(input logic [31:0] d, input logic [3:0] k,
                                        input logic l, input logic u);
      return {d, k, l, u};
   endfunction

   function automatic logic [37:0] cur_beat();
      return {io_axis_tdata, io_axis_tkeep, io_axis_tlast, io_axis_tuser};
   endfunction

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   task automatic drive_rec(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] length, input logic [15:0] csum,
                            input logic [15:0] len, input logic [PB*8-1:0] data);
      io_in_bits_udp_head_src_port = src;
      io_in_bits_udp_head_dst_port = dst;
      io_in_bits_udp_head_length   = length;
      io_in_bits_udp_head_checksum = csum;
      io_in_bits_len               = len;
      io_in_bits_data              = data;
   endtask

   // Called on a falling edge. Returns on the falling edge right after the
   // accepting rising edge, where the first beat must already be valid.
   task automatic send_rec(input bit hold, input string tag, output int waits);
      waits = 0;
      io_in_valid = 1'b1;
      while (!io_in_ready && waits < 50) begin
         @(negedge clock);
         waits++;
      end
      check({tag, "_accept"}, 64'(io_in_ready), 64'd1);
      @(negedge clock);
      if (!hold) io_in_valid = 1'b0;
      check({tag, "_latency"}, 64'(io_axis_tvalid), 64'd1);
   endtask

   // mode 0: tready always 1; mode 1: tready pattern 1,0,0,1 repeating.
   // Returns on the falling edge where the tlast beat is presented with
   // tready high, then compares against exp_q.
   task automatic collect(input int mode, input string tag);
      logic [37:0] held;
      bit          stalled;
      bit          done;
      int          cyc;
      held    = '0;
      stalled = 1'b0;
      done    = 1'b0;
      cyc     = 0;
      got_q.delete();
      while (!done && cyc < 200) begin
         io_axis_tready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (io_axis_tvalid) begin
            if (stalled) check({tag, "_stable"}, 64'(cur_beat()), 64'(held));
            stalled = !io_axis_tready;
            held    = cur_beat();
            if (io_axis_tready) begin
               got_q.push_back(cur_beat());
               if (io_axis_tlast) done = 1'b1;
            end
         end else begin
            check({tag, "_tvalid_held"}, 64'(stalled), 64'd0);
         end
         if (!done) begin
            @(negedge clock);
            cyc++;
         end
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      end
   endtask

   task automatic post_frame(input string tag);
      @(negedge clock);
      check({tag, "_idle_tvalid"}, 64'(io_axis_tvalid), 64'd0);
      check({tag, "_idle_ready"}, 64'(io_in_ready), 64'd1);
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   logic [PB*8-1:0] d;
   int              w;
   logic            exp_lenchk_user;

   initial begin
`ifdef UDP_EMIT_LEN_CHECK_EN
      exp_lenchk_user = 1'b1;
`else
      exp_lenchk_user = 1'b0;
`endif

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_ready",  64'(io_in_ready),    64'd0);
      check("rst_tvalid", 64'(io_axis_tvalid), 64'd0);
      check("rst_tdata",  64'(io_axis_tdata),  64'd0);
      check("rst_tkeep",  64'(io_axis_tkeep),  64'd0);
      check("rst_tlast",  64'(io_axis_tlast),  64'd0);
      check("rst_tuser",  64'(io_axis_tuser),  64'd0);
      reset = 1'b1;
      @(negedge clock);
      check("rst_release_ready", 64'(io_in_ready), 64'd1);

      // len=4 basic frame
      d = '0;
      d[31:0]  = 32'h82345678;
      d[63:32] = 32'hFFFFFFFF;
      drive_rec(16'h1234, 16'h5678, 16'h000C, 16'hABCD, 16'd4, d);
      exp_q = '{beat(32'h56781234, 4'hF, 1'b0, 1'b0),
                beat(32'hABCD000C, 4'hF, 1'b0, 1'b0),
                beat(32'h82345678, 4'hF, 1'b1, 1'b0)};
      send_rec(1'b0, "len4", w);
      collect(0, "len4");
      post_frame("len4");

      // len=6: partial last beat, upper lanes zeroed
      d = '0;
      d[63:0] = 64'hFFFF_6655_4433_2211;
      drive_rec(16'h0001, 16'h0002, 16'h000E, 16'h0000, 16'd6, d);
      exp_q = '{beat(32'h00020001, 4'hF, 1'b0, 1'b0),
                beat(32'h0000000E, 4'hF, 1'b0, 1'b0),
                beat(32'h44332211, 4'hF, 1'b0, 1'b0),
                beat(32'h00006655, 4'h3, 1'b1, 1'b0)};
      send_rec(1'b0, "len6", w);
      collect(0, "len6");
      post_frame("len6");

      // Same record with sink stalls: identical beat sequence
      send_rec(1'b0, "stall", w);
      collect(1, "stall");
      post_frame("stall");

      // len=0: tlast on the second header beat
      d = '1;
      drive_rec(16'hAAAA, 16'hBBBB, 16'h0008, 16'h1111, 16'd0, d);
      exp_q = '{beat(32'hBBBBAAAA, 4'hF, 1'b0, 1'b0),
                beat(32'h11110008, 4'hF, 1'b1, 1'b0)};
      send_rec(1'b0, "len0", w);
      collect(0, "len0");
      post_frame("len0");

      // len=70 > 64: truncated to 16 full beats, tuser on tlast
      d = '0;
      for (int i = 0; i < PB; i++) d[i*8 +: 8] = 8'(i);
      drive_rec(16'hC001, 16'hD002, 16'h004E, 16'h5A5A, 16'd70, d);
      exp_q.delete();
      exp_q.push_back(beat(32'hD002C001, 4'hF, 1'b0, 1'b0));
      exp_q.push_back(beat(32'h5A5A004E, 4'hF, 1'b0, 1'b0));
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(beat({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 4'hF,
                              k == 15, k == 15));
      end
      send_rec(1'b0, "len70", w);
      collect(0, "len70");
      post_frame("len70");

      // Back-to-back records with io_in_valid held high
      d = '0;
      d[31:0] = 32'h82345678;
      drive_rec(16'h1234, 16'h5678, 16'h000C, 16'hABCD, 16'd4, d);
      exp_q = '{beat(32'h56781234, 4'hF, 1'b0, 1'b0),
                beat(32'hABCD000C, 4'hF, 1'b0, 1'b0),
                beat(32'h82345678, 4'hF, 1'b1, 1'b0)};
      send_rec(1'b1, "b2b_a", w);
      collect(0, "b2b_a");
      @(negedge clock);
      check("b2b_gap_ready",  64'(io_in_ready),    64'd1);
      check("b2b_gap_tvalid", 64'(io_axis_tvalid), 64'd0);
      drive_rec(16'hAAAA, 16'hBBBB, 16'h0008, 16'h1111, 16'd0, d);
      exp_q = '{beat(32'hBBBBAAAA, 4'hF, 1'b0, 1'b0),
                beat(32'h11110008, 4'hF, 1'b1, 1'b0)};
      send_rec(1'b0, "b2b_b", w);
      check("b2b_b_wait", 64'(w), 64'd0);
      collect(0, "b2b_b");
      post_frame("b2b_b");

      // Reset asserted while in PAY
      d = '0;
      for (int i = 0; i < PB; i++) d[i*8 +: 8] = 8'(i);
      drive_rec(16'hC001, 16'hD002, 16'h004E, 16'h5A5A, 16'd70, d);
      send_rec(1'b0, "midrst", w);
      io_axis_tready = 1'b1;
      repeat (4) @(negedge clock);
      check("midrst_in_pay", 64'(io_axis_tdata), 64'h0B0A0908);
      #2 reset = 1'b0;
      #1;
      check("midrst_tvalid", 64'(io_axis_tvalid), 64'd0);
      check("midrst_tlast",  64'(io_axis_tlast),  64'd0);
      check("midrst_ready",  64'(io_in_ready),    64'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_release_ready",  64'(io_in_ready),    64'd1);
      check("midrst_release_tvalid", 64'(io_axis_tvalid), 64'd0);

      // UDP length field mismatch (0x000B vs len+8 = 0x000C)
      d = '0;
      d[31:0] = 32'h82345678;
      drive_rec(16'h1234, 16'h5678, 16'h000B, 16'hABCD, 16'd4, d);
      exp_q = '{beat(32'h56781234, 4'hF, 1'b0, 1'b0),
                beat(32'hABCD000B, 4'hF, 1'b0, 1'b0),
                beat(32'h82345678, 4'hF, 1'b1, exp_lenchk_user)};
      send_rec(1'b0, "lenchk", w);
      collect(0, "lenchk");
      post_frame("lenchk");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_axis_emitter.md
Name: udp_axis_emitter

Overview:
- Downstream stage of the AXIS analysis block: consumes one parsed UDP record per handshake (payload vector, payload length, UDP header fields).
- Re-serialises the record onto a 32-bit AXI-Stream master: 2 header beats, then payload beats, with `tkeep` and `tlast`.
- Feeds the MAC-side transmit path.

Parameters:
- `PAYLOAD_BYTES`, 64: capacity of `io_in_bits_data` in bytes. Must be a multiple of 4.
- `TDATA_W`, 32: AXIS data width. Only 32 is supported; other values are an elaboration error.

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `io_in_valid`  in  1  record valid
- `io_in_ready`  out  1  record accepted when valid && ready
- `io_in_bits_data`  in  PAYLOAD_BYTES*8  payload; byte i = bits [8i+7:8i]
- `io_in_bits_len`  in  16  payload length in bytes
- `io_in_bits_udp_head_src_port`  in  16  UDP source port
- `io_in_bits_udp_head_dst_port`  in  16  UDP destination port
- `io_in_bits_udp_head_length`  in  16  UDP length field
- `io_in_bits_udp_head_checksum`  in  16  UDP checksum field
- `io_axis_tvalid`  out  1  beat valid
- `io_axis_tready`  in  1  sink ready
- `io_axis_tdata`  out  32  beat data
- `io_axis_tkeep`  out  4  byte enables
- `io_axis_tlast`  out  1  last beat of frame
- `io_axis_tuser`  out  1  frame error, valid only on the tlast beat

Behaviour:
- Reset (`reset`=0, asynchronous): state IDLE; `io_in_ready`=0; `tvalid`=0; `tdata`=0; `tkeep`=0; `tlast`=0; `tuser`=0; beat counter=0.
- `io_in_ready`=1 in the first cycle after reset deasserts.
- FSM states: IDLE, HDR0, HDR1, PAY.
  - IDLE: `io_in_ready`=1. On handshake, register all inputs and go to HDR0. `tvalid` rises the next cycle (latency 1).
  - HDR0: `tdata` = {dst_port, src_port}, i.e. src_port in [15:0]; `tkeep`=4'hF. On `tvalid && tready`, go to HDR1.
  - HDR1: `tdata` = {checksum, length}. If eff_len==0 this beat carries `tlast`=1 and the FSM returns to IDLE on handshake; otherwise go to PAY with beat counter=0.
  - PAY: beat k carries bytes 4k..4k+3, with byte 4k in [7:0]. Number of beats = ceil(eff_len/4).
    - Last beat: `tlast`=1. `tkeep` = 4'hF if eff_len%4==0, else (1<<(eff_len%4))-1.
    - Byte lanes with `tkeep`=0 are driven 0. Non-last beats have `tkeep`=4'hF.
    - After the last handshake, return to IDLE.
- eff_len = min(len, PAYLOAD_BYTES). If len > PAYLOAD_BYTES, the frame is truncated and `tuser`=1 on its tlast beat.
- AXIS rule: `tdata`, `tkeep`, `tlast` and `tuser` are held stable while `tvalid && !tready`. `tvalid` never drops until the beat is accepted.
- Throughput: `io_in_ready` is high only in IDLE, so there is exactly 1 idle cycle between back-to-back frames. With `tready` held high, a frame of n payload beats takes 2+n+1 cycles per record.
- Outputs are registered; there is no combinational path from `tready` to `tdata`.
- `tready` is ignored while `tvalid`=0.
- Reset mid-frame: `tvalid` drops immediately (async); the partial frame is discarded with no tlast emitted.
- Beat counter width: clog2(PAYLOAD_BYTES/4)+1. It does not wrap, because eff_len ≤ PAYLOAD_BYTES.

Optional Feature:
- Macro `UDP_EMIT_LEN_CHECK_EN`.
- Defined: compare head_length against len+8 (16-bit, modulo 2^16). On mismatch, `tuser`=1 on the tlast beat, OR'd with the oversize flag. The frame is still emitted unchanged.
- Undefined: no comparison; `tuser` reflects only the oversize flag.

Decomposition:
- Shared package `udp_pkg`:
  - FSM state enum (IDLE/HDR0/HDR1/PAY)
  - `udp_head_t` struct (src_port, dst_port, length, checksum)
  - constant `UDP_HDR_BYTES`=8
  - function `keep_from_rem(rem[1:0])`
- Sub-module `udp_beat_mux`: combinational selection of the 32-bit lane and `tkeep` for a given beat index and eff_len from the registered payload. Everything else stays in the top module.

Test Plan:
- Record src=0x1234, dst=0x5678, length=0x000C, csum=0xABCD, len=4, data[31:0]=0x82345678, `tready`=1 -> 3 beats:
  - 0x56781234 keep F
  - 0xABCD000C keep F
  - 0x82345678 keep F with tlast=1, tuser=0
  - first tvalid one cycle after handshake.
- len=6 -> payload beats bytes 0-3 keep F, then bytes 4-5 keep 4'h3 with upper lanes 0 and tlast=1. len=0 -> tlast on HDR1 beat.
- len=70 (PAYLOAD_BYTES=64) -> 16 payload beats, last keep F, tuser=1.
- `tready` toggled 1,0,0,1 per cycle during HDR1/PAY -> data and keep stable during stalls; beat sequence identical to the no-stall run.
- Two back-to-back records with `io_in_valid` held high -> second accepted exactly 1 cycle after the first frame's tlast handshake. Reset asserted in PAY -> tvalid=0 immediately, io_in_ready=1 the cycle after release.
- With `UDP_EMIT_LEN_CHECK_EN`: len=4, length=0x000B -> tuser=1 on tlast. Without the macro the same stimulus gives tuser=0.
